// File: rtl/vanilla_pkg.sv
// -----------------------------------------------------------------------------
// vanilla_pkg
// Shared types and constants for the MCS-to-WISHBONE bridge.
//   brg_state_t  : bridge FSM state encoding
//   DEF_ERR_DATA : read data handed back to the MCS on bus error or timeout
// -----------------------------------------------------------------------------
package vanilla_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } brg_state_t;

   localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;

endpackage : vanilla_pkg

// File: rtl/brg_timeout.sv
// -----------------------------------------------------------------------------
// brg_timeout
// Wait-state watchdog for the bridge. Counts BUSY cycles that see neither ACK
// nor ERR and flags the cycle in which the count reaches TIMEOUT_CYC, so the
// FSM leaves BUSY on that same edge.
// Ports:
//   clk      : system clock
//   reset_n  : synchronous active-low reset
//   clr      : clear the count (request accepted, entering BUSY)
//   en       : a BUSY cycle without ACK/ERR
//   expired  : this cycle is the TIMEOUT_CYC-th wait cycle
// Parameters:
//   TIMEOUT_CYC : wait cycles before abort, >= 1
// -----------------------------------------------------------------------------
module brg_timeout #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt;

   // Saturates at TIMEOUT_CYC so a stalled count can never wrap.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != CW'(TIMEOUT_CYC))) begin
         cnt <= cnt + CW'(1);
      end
   end

   // The increment on this edge would reach TIMEOUT_CYC, so abort now.
   assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule : brg_timeout

// File: rtl/mcs_wb_bridge.sv
// -----------------------------------------------------------------------------
// mcs_wb_bridge
// Registered MicroBlaze MCS I/O bus to WISHBONE classic bridge. Decodes the
// FPro window, captures one MCS request, runs a single WISHBONE cycle with any
// number of wait states and finishes every accepted request with exactly one
// io_ready pulse (also on bus error and on timeout).
//
// Build option:
//   MCS_WB_BRIDGE_TIMEOUT_EN : when defined, a brg_timeout watchdog aborts a
//                              cycle after TIMEOUT_CYC wait cycles. When
//                              undefined, BUSY exits only on ACK_I or ERR_I
//                              and a silent slave hangs the bus.
//
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   io_addr_strobe       : MCS request strobe (one cycle)
//   io_read_strobe       : MCS read qualifier
//   io_write_strobe      : MCS write qualifier
//   io_byte_enable       : MCS byte lanes
//   io_address           : MCS byte address
//   io_write_data        : MCS write data
//   io_read_data         : read data back to the MCS
//   io_ready             : one-cycle completion pulse
//   CYC_O, STB_O, WE_O   : WISHBONE cycle, strobe, write enable
//   SEL_O                : WISHBONE byte select
//   ADDR_O               : WISHBONE word address
//   DAT_O / DAT_I        : WISHBONE write / read data
//   ACK_I, ERR_I         : WISHBONE acknowledge / error
//   bus_err_o            : sticky error flag, cleared only by reset
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an in-window MCS strobe
// BUSY  | WISHBONE cycle in progress, CYC_O/STB_O high
// RESP  | io_ready high for one cycle, strobes dropped
// -----------------------------------------------------------------------------
module mcs_wb_bridge
   import vanilla_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                MMIO_AW     = 21,
   parameter int                DW          = 32,
   parameter logic [ADDR_W-1:0] BRG_BASE    = ADDR_W'(32'hc000_0000),
   parameter int                TIMEOUT_CYC = 255,
   parameter logic [DW-1:0]     ERR_DATA    = DW'(DEF_ERR_DATA)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                io_addr_strobe,
   input  logic                io_read_strobe,
   input  logic                io_write_strobe,
   input  logic [DW/8-1:0]     io_byte_enable,
   input  logic [ADDR_W-1:0]   io_address,
   input  logic [DW-1:0]       io_write_data,
   output logic [DW-1:0]       io_read_data,
   output logic                io_ready,
   output logic                CYC_O,
   output logic                STB_O,
   output logic                WE_O,
   output logic [DW/8-1:0]     SEL_O,
   output logic [MMIO_AW-1:0]  ADDR_O,
   output logic [DW-1:0]       DAT_O,
   input  logic [DW-1:0]       DAT_I,
   input  logic                ACK_I,
   input  logic                ERR_I,
   output logic                bus_err_o
);

   brg_state_t state;
   logic       in_window;
   logic       accept;
   logic       expired;

   // Top byte must match the base; the next bit selects the upper half of
   // the window, which belongs to another agent.
   assign in_window = (io_address[ADDR_W-1:ADDR_W-8] == BRG_BASE[ADDR_W-1:ADDR_W-8])
                      && !io_address[ADDR_W-9];
   assign accept    = (state == IDLE) && io_addr_strobe && in_window;

   // Word addressing: byte offset bits never reach the bus.
   logic unused_addr;
   assign unused_addr = ^io_address[1:0];

`ifdef MCS_WB_BRIDGE_TIMEOUT_EN
   brg_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept),
      .en      ((state == BUSY) && !ACK_I && !ERR_I),
      .expired (expired)
   );
`else
   assign expired = 1'b0;

   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= IDLE;
         io_read_data <= '0;
         io_ready     <= 1'b0;
         CYC_O        <= 1'b0;
         STB_O        <= 1'b0;
         WE_O         <= 1'b0;
         SEL_O        <= '0;
         ADDR_O       <= '0;
         DAT_O        <= '0;
         bus_err_o    <= 1'b0;
      end else begin
         io_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= BUSY;
                  CYC_O  <= 1'b1;
                  STB_O  <= 1'b1;
                  ADDR_O <= io_address[MMIO_AW+1:2];
                  DAT_O  <= io_write_data;
                  SEL_O  <= io_byte_enable;
                  WE_O   <= io_write_strobe & ~io_read_strobe;
               end
            end
            BUSY: begin
               // ACK takes precedence over a simultaneous ERR.
               if (ACK_I) begin
                  state    <= RESP;
                  CYC_O    <= 1'b0;
                  STB_O    <= 1'b0;
                  io_ready <= 1'b1;
                  if (!WE_O) begin
                     io_read_data <= DAT_I;
                  end
               end else if (ERR_I || expired) begin
                  state        <= RESP;
                  CYC_O        <= 1'b0;
                  STB_O        <= 1'b0;
                  io_ready     <= 1'b1;
                  io_read_data <= ERR_DATA;
                  bus_err_o    <= 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               CYC_O <= 1'b0;
               STB_O <= 1'b0;
            end
         endcase
      end
   end

endmodule : mcs_wb_bridge

// File: tb/tb_mcs_wb_bridge.sv
// -----------------------------------------------------------------------------
// tb_mcs_wb_bridge
// Directed self-checking bench for mcs_wb_bridge. Inputs change 1 time unit
// after each rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_mcs_wb_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        io_addr_strobe;
   logic        io_read_strobe;
   logic        io_write_strobe;
   logic [3:0]  io_byte_enable;
   logic [31:0] io_address;
   logic [31:0] io_write_data;
   logic [31:0] io_read_data;
   logic        io_ready;
   logic        CYC_O;
   logic        STB_O;
   logic        WE_O;
   logic [3:0]  SEL_O;
   logic [20:0] ADDR_O;
   logic [31:0] DAT_O;
   logic [31:0] DAT_I;
   logic        ACK_I;
   logic        ERR_I;
   logic        bus_err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mcs_wb_bridge #(
      .TIMEOUT_CYC (8)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .io_addr_strobe  (io_addr_strobe),
      .io_read_strobe  (io_read_strobe),
      .io_write_strobe (io_write_strobe),
      .io_byte_enable  (io_byte_enable),
      .io_address      (io_address),
      .io_write_data   (io_write_data),
      .io_read_data    (io_read_data),
      .io_ready        (io_ready),
      .CYC_O           (CYC_O),
      .STB_O           (STB_O),
      .WE_O            (WE_O),
      .SEL_O           (SEL_O),
      .ADDR_O          (ADDR_O),
      .DAT_O           (DAT_O),
      .DAT_I           (DAT_I),
      .ACK_I           (ACK_I),
      .ERR_I           (ERR_I),
      .bus_err_o       (bus_err_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_rd"},     io_read_data, 32'h0);
      chk({pfx, "_ready"},  32'(io_ready), 32'h0);
      chk({pfx, "_cyc"},    32'(CYC_O), 32'h0);
      chk({pfx, "_stb"},    32'(STB_O), 32'h0);
      chk({pfx, "_we"},     32'(WE_O), 32'h0);
      chk({pfx, "_sel"},    32'(SEL_O), 32'h0);
      chk({pfx, "_addr"},   32'(ADDR_O), 32'h0);
      chk({pfx, "_dato"},   DAT_O, 32'h0);
      chk({pfx, "_buserr"}, 32'(bus_err_o), 32'h0);
   endtask

   task automatic strobe(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] be);
      io_addr_strobe  = 1'b1;
      io_address      = addr;
      io_write_strobe = wr;
      io_read_strobe  = ~wr;
      io_write_data   = wd;
      io_byte_enable  = be;
   endtask

   task automatic idle_bus();
      io_addr_strobe  = 1'b0;
      io_read_strobe  = 1'b0;
      io_write_strobe = 1'b0;
   endtask

   initial begin
      int n_rdy;
      reset_n = 1'b0;
      idle_bus();
      io_byte_enable = 4'h0;
      io_address     = 32'h0;
      io_write_data  = 32'h0;
      DAT_I          = 32'h0;
      ACK_I          = 1'b0;
      ERR_I          = 1'b0;

      // Reset state
      tick(); tick(); tick();
      chk_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Zero-wait write: ready two cycles after the strobe cycle
      strobe(32'hC000_0010, 1'b1, 32'h1234_5678, 4'b1111);
      tick();
      idle_bus();
      chk("wr_cyc",  32'(CYC_O), 32'h1);
      chk("wr_stb",  32'(STB_O), 32'h1);
      chk("wr_addr", 32'(ADDR_O), 32'h4);
      chk("wr_sel",  32'(SEL_O), 32'hF);
      chk("wr_we",   32'(WE_O), 32'h1);
      chk("wr_dato", DAT_O, 32'h1234_5678);
      chk("wr_ready_early", 32'(io_ready), 32'h0);
      ACK_I = 1'b1;
      tick();
      ACK_I = 1'b0;
      chk("wr_ready", 32'(io_ready), 32'h1);
      chk("wr_cyc_low", 32'(CYC_O), 32'h0);
      chk("wr_rd_unchanged", io_read_data, 32'h0);
      tick();
      chk("wr_ready_pulse", 32'(io_ready), 32'h0);

      // Read with 5 wait states: ready seven cycles after the strobe cycle
      strobe(32'hC000_0020, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
      chk("rd_addr", 32'(ADDR_O), 32'h8);
      chk("rd_we",   32'(WE_O), 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("rd_wait_cyc",   32'(CYC_O), 32'h1);
         chk("rd_wait_ready", 32'(io_ready), 32'h0);
         tick();
      end
      ACK_I = 1'b1;
      DAT_I = 32'hA5A5_0001;
      tick();
      ACK_I = 1'b0;
      DAT_I = 32'h0;
      chk("rd_ready", 32'(io_ready), 32'h1);
      chk("rd_data",  io_read_data, 32'hA5A5_0001);

      // Strobe during RESP is dropped
      strobe(32'hC000_0030, 1'b1, 32'h5555_AAAA, 4'b1111);
      tick();
      idle_bus();
      chk("resp_drop_cyc", 32'(CYC_O), 32'h0);

      // Back-to-back accept right after RESP; ACK and ERR together, ACK wins
      strobe(32'hC000_0004, 1'b1, 32'h0BAD_F00D, 4'b0101);
      tick();
      idle_bus();
      chk("b2b_cyc",  32'(CYC_O), 32'h1);
      chk("b2b_addr", 32'(ADDR_O), 32'h1);
      chk("b2b_sel",  32'(SEL_O), 32'h5);
      ACK_I = 1'b1;
      ERR_I = 1'b1;
      tick();
      ACK_I = 1'b0;
      ERR_I = 1'b0;
      chk("prec_ready",  32'(io_ready), 32'h1);
      chk("prec_buserr", 32'(bus_err_o), 32'h0);
      chk("prec_rd",     io_read_data, 32'hA5A5_0001);
      tick();

      // Out-of-window strobes: bit 23 set, and wrong top byte
      strobe(32'hC080_0000, 1'b0, 32'h0, 4'b1111);
      tick();
      chk("oow23_cyc", 32'(CYC_O), 32'h0);
      strobe(32'h8000_0000, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
      chk("oowtop_cyc", 32'(CYC_O), 32'h0);
      tick();
      chk("oow_ready", 32'(io_ready), 32'h0);
      chk("oow_cyc2",  32'(CYC_O), 32'h0);

      // Bus error on a read, sticky through the next good transfer
      strobe(32'hC000_0040, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
      ERR_I = 1'b1;
      tick();
      ERR_I = 1'b0;
      chk("err_ready",  32'(io_ready), 32'h1);
      chk("err_rd",     io_read_data, 32'hDEAD_BEEF);
      chk("err_buserr", 32'(bus_err_o), 32'h1);
      tick();
      strobe(32'hC000_0044, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
      ACK_I = 1'b1;
      DAT_I = 32'h1111_2222;
      tick();
      ACK_I = 1'b0;
      DAT_I = 32'h0;
      chk("good_ready",  32'(io_ready), 32'h1);
      chk("good_rd",     io_read_data, 32'h1111_2222);
      chk("good_buserr", 32'(bus_err_o), 32'h1);
      tick();

      // Silent slave
      strobe(32'hC000_0050, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
`ifdef MCS_WB_BRIDGE_TIMEOUT_EN
      for (int i = 0; i < 8; i++) begin
         chk("to_busy_cyc", 32'(CYC_O), 32'h1);
         tick();
      end
      chk("to_cyc_low", 32'(CYC_O), 32'h0);
      chk("to_ready",   32'(io_ready), 32'h1);
      chk("to_rd",      io_read_data, 32'hDEAD_BEEF);
      chk("to_buserr",  32'(bus_err_o), 32'h1);
      tick();
      strobe(32'hC000_0060, 1'b0, 32'h0, 4'b1111);
      tick();
      idle_bus();
`else
      n_rdy = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (io_ready) n_rdy++;
      end
      chk("hang_ready", 32'(n_rdy), 32'h0);
      chk("hang_stb",   32'(STB_O), 32'h1);
`endif
      chk("pre_rst_cyc", 32'(CYC_O), 32'h1);

      // Reset mid-BUSY
      reset_n = 1'b0;
      tick();
      chk_all_zero("midrst");
      reset_n = 1'b1;
      tick();
      tick();
      chk("postrst_ready", 32'(io_ready), 32'h0);
      chk("postrst_cyc",   32'(CYC_O), 32'h0);

      // Next request completes normally
      strobe(32'hC000_0008, 1'b1, 32'hCAFE_0001, 4'b0011);
      tick();
      idle_bus();
      chk("after_addr", 32'(ADDR_O), 32'h2);
      chk("after_sel",  32'(SEL_O), 32'h3);
      chk("after_we",   32'(WE_O), 32'h1);
      chk("after_dato", DAT_O, 32'hCAFE_0001);
      ACK_I = 1'b1;
      tick();
      ACK_I = 1'b0;
      chk("after_ready",  32'(io_ready), 32'h1);
      chk("after_rd",     io_read_data, 32'h0);
      chk("after_buserr", 32'(bus_err_o), 32'h0);
      tick();
      chk("after_ready_pulse", 32'(io_ready), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_mcs_wb_bridge

// File: doc/mcs_wb_bridge.md
# mcs_wb_bridge

Registered MicroBlaze MCS I/O bus to WISHBONE classic bridge, the parametrised successor of the combinational MCS bridge. It decodes the FPro window, captures each MCS request, and runs a single WISHBONE cycle that may take any number of wait states. It ends every accepted request with exactly one `io_ready` pulse, including on bus error and on the optional timeout. It sits between the MCS I/O module and the MMIO controller.

## Interface
Parameters:
- `BRG_BASE`, 32'hc000_0000, base of the bridge window; only bits [ADDR_W-1:ADDR_W-8] are compared.
- `ADDR_W`, 32, MCS byte address width.
- `MMIO_AW`, 21, WISHBONE word address width.
- `DW`, 32, data width; a multiple of 8.
- `TIMEOUT_CYC`, 255, number of wait cycles before abort; must be ≥1.
- `ERR_DATA`, 32'hDEAD_BEEF, read data returned on error or timeout.

Ports:
- `clk` in 1: the single clock.
- `reset_n` in 1: reset; synchronous, active-low.
- `io_addr_strobe` in 1: MCS request strobe, one cycle.
- `io_read_strobe` in 1: MCS read qualifier.
- `io_write_strobe` in 1: MCS write qualifier.
- `io_byte_enable` in DW/8: MCS byte lanes.
- `io_address` in ADDR_W: MCS byte address.
- `io_write_data` in DW: MCS write data.
- `io_read_data` out DW: read data returned to the MCS.
- `io_ready` out 1: one-cycle completion pulse.
- `CYC_O`, `STB_O`, `WE_O` out 1 each: WISHBONE cycle, strobe and write enable.
- `SEL_O` out DW/8: WISHBONE byte select.
- `ADDR_O` out MMIO_AW: WISHBONE word address.
- `DAT_O` out DW: WISHBONE write data.
- `DAT_I` in DW: WISHBONE read data.
- `ACK_I`, `ERR_I` in 1 each: WISHBONE acknowledge and error.
- `bus_err_o` out 1: sticky error flag; cleared only by reset.

## Operation
FSM states:
- IDLE → BUSY when a request is accepted.
- BUSY → RESP on `ACK_I`, on `ERR_I`, or on timeout.
- RESP → IDLE unconditionally.

Request acceptance:
- Accepted only in IDLE, when all of these hold:
  - `io_addr_strobe`=1;
  - `io_address[ADDR_W-1:ADDR_W-8]` equals the same bits of `BRG_BASE`;
  - `io_address[ADDR_W-9]`=0.
- On accept, the bridge registers:
  - `ADDR_O` ← `io_address[MMIO_AW+1:2]`;
  - `DAT_O` ← `io_write_data`;
  - `SEL_O` ← `io_byte_enable`;
  - `WE_O` ← `io_write_strobe & ~io_read_strobe`.
- Strobes outside the window are ignored: no cycle is started and no `io_ready` is produced.
- A strobe that arrives in BUSY or RESP is dropped. This is a protocol violation and is not queued.

WISHBONE cycle:
- `CYC_O` = `STB_O` = 1 exactly while in BUSY.
- `ADDR_O`, `DAT_O`, `SEL_O` and `WE_O` stay stable throughout BUSY.

Completion:
- ACK with precedence: if `ACK_I` and `ERR_I` are high together, ACK wins.
- On ACK: read cycles latch `DAT_I` into `io_read_data`; write cycles leave `io_read_data` unchanged.
- On `ERR_I` or timeout: `io_read_data` ← `ERR_DATA` (reads and writes alike) and `bus_err_o` ← 1.
- `io_ready` = 1 only in RESP, for one cycle.

Reset:
- Every output resets to 0: `io_read_data`, `io_ready`, `CYC_O`, `STB_O`, `WE_O`, `SEL_O`, `ADDR_O`, `DAT_O`, `bus_err_o`. The timeout counter also resets to 0.
- Reset mid-cycle: the FSM returns to IDLE and `CYC_O` falls on the next edge. No `io_ready` is produced for the aborted request.

## Timing
- Strobe at edge N → `CYC_O`/`STB_O` high from N+1.
- ACK sampled at edge N+k (k≥1) → `CYC_O` low and `io_ready` high at N+k+1.
- Zero-wait-state slave: `io_ready` 2 cycles after the strobe.
- Back-to-back: a new strobe is accepted in the cycle after `io_ready`.
- Timeout:
  - Counter clears on entry to BUSY and increments on each BUSY cycle without ACK or ERR.
  - Reaching `TIMEOUT_CYC` forces BUSY→RESP on that edge.
  - Counter width is $clog2(TIMEOUT_CYC+1).

## Configuration
- Macro: `MCS_WB_BRIDGE_TIMEOUT_EN`.
- Defined: timeout counter present; behaviour as above.
- Undefined:
  - counter is not instantiated;
  - BUSY exits only on `ACK_I` or `ERR_I`;
  - `TIMEOUT_CYC` is unused;
  - a missing ACK hangs the bus by design.

## Structure
- In `vanilla_pkg`:
  - FSM enum `brg_state_t` {IDLE, BUSY, RESP};
  - default `ERR_DATA` constant.
- Sub-module `brg_timeout`:
  - inputs `clk`, `reset_n`, `clr`, `en`;
  - output `expired`;
  - parametrised by `TIMEOUT_CYC`;
  - instantiated only under the macro.

## Test plan
- Write 0x1234_5678 to 0xC000_0010, byte enable 4'b1111, ACK one cycle after `CYC_O` rises → `ADDR_O`=4, `SEL_O`=4'hF, `WE_O`=1; `io_ready` 2 cycles after the strobe.
- Read 0xC000_0020, slave with 5 wait states returning 0xA5A5_0001 → `ADDR_O`=8; `io_read_data`=0xA5A5_0001 with `io_ready` 7 cycles after the strobe.
- Strobe at 0xC080_0000 (bit 23 set) and at 0x8000_0000 → `CYC_O` stays 0, no `io_ready`.
- Read with `ERR_I` asserted → `io_read_data`=0xDEAD_BEEF, `bus_err_o`=1 and stays set through the next good transfer.
- With the macro defined and `TIMEOUT_CYC`=8, slave never ACKs → `CYC_O` drops after 8 busy cycles, `io_ready` pulses, `bus_err_o`=1. Without the macro, `CYC_O` is still high after 1000 cycles.
- `reset_n` low during BUSY → all outputs 0 on the next edge; no `io_ready`; the next request completes normally.
